// File: rtl/headgen_mgmt_loader.sv
// headgen_mgmt_loader: turns a framed 16-bit command stream into single-cycle
// writes on the three header-generator management RAM ports (microcode,
// L3 length, IPv4 checksum). Frame = header word, count word, count data words.
module headgen_mgmt_loader #(
  parameter int OFF_W  = 9,
  parameter int VLAN_W = 4,
  parameter int MC_DW  = 9,
  parameter int TBL_DW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             cmd_data,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic                    err_clr,
  output logic [MC_DW-1:0]        writedata_mgmt_0,
  output logic [VLAN_W+OFF_W-1:0] writeaddr_mgmt_0,
  output logic                    we_mgmt_0,
  output logic [TBL_DW-1:0]       writedata_mgmt_1,
  output logic [VLAN_W-1:0]       writeaddr_mgmt_1,
  output logic                    we_mgmt_1,
  output logic [TBL_DW-1:0]       writedata_mgmt_2,
  output logic [VLAN_W-1:0]       writeaddr_mgmt_2,
  output logic                    we_mgmt_2
);

  typedef enum logic [2:0] {S_HDR, S_CNT, S_DATA, S_DRAIN, S_DONE} state_t;

  localparam logic [1:0] TGT_MC  = 2'd0;
  localparam logic [1:0] TGT_L3  = 2'd1;
  localparam logic [1:0] TGT_CHK = 2'd2;

  state_t                    state_q, state_d;
  logic [1:0]                tgt_q, tgt_d;
  logic [VLAN_W-1:0]         vlan_q, vlan_d;
  logic [OFF_W-1:0]          off_q, off_d;
  logic [15:0]               rem_q, rem_d;
  logic                      err_q, err_d, set_err;
  logic                      we0_q, we0_d, we1_q, we1_d, we2_q, we2_d;
  logic [VLAN_W+OFF_W-1:0]   addr0_q, addr0_d;
  logic [MC_DW-1:0]          data0_q, data0_d;
  logic [VLAN_W-1:0]         addr1_q, addr1_d, addr2_q, addr2_d;
  logic [TBL_DW-1:0]         data1_q, data1_d, data2_q, data2_d;
  logic                      accept;

  // reserved header bit carries no meaning
  logic unused_rsvd;
  assign unused_rsvd = cmd_data[9];

  assign cmd_ready = (state_q != S_DONE);
  assign accept    = cmd_valid & cmd_ready;
  assign busy      = (state_q != S_HDR);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;

  assign we_mgmt_0        = we0_q;
  assign writeaddr_mgmt_0 = addr0_q;
  assign writedata_mgmt_0 = data0_q;
  assign we_mgmt_1        = we1_q;
  assign writeaddr_mgmt_1 = addr1_q;
  assign writedata_mgmt_1 = data1_q;
  assign we_mgmt_2        = we2_q;
  assign writeaddr_mgmt_2 = addr2_q;
  assign writedata_mgmt_2 = data2_q;

  // frame parser: next state, frame context and the registered write to issue
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    vlan_d  = vlan_q;
    off_d   = off_q;
    rem_d   = rem_q;
    set_err = 1'b0;
    we0_d   = 1'b0;
    we1_d   = 1'b0;
    we2_d   = 1'b0;
    addr0_d = addr0_q;
    data0_d = data0_q;
    addr1_d = addr1_q;
    data1_d = data1_q;
    addr2_d = addr2_q;
    data2_d = data2_q;
    case (state_q)
      S_HDR: if (accept) begin
        tgt_d   = cmd_data[15:14];
        vlan_d  = cmd_data[13:10];
        off_d   = cmd_data[8:0];
        state_d = S_CNT;
      end
      S_CNT: if (accept) begin
        rem_d = cmd_data;
        if (cmd_data == 16'd0) begin
          set_err = 1'b1;
          state_d = S_HDR;
        end else if (tgt_q == 2'd3 || (tgt_q != TGT_MC && cmd_data > 16'd1)) begin
          set_err = 1'b1;
          state_d = S_DRAIN;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: if (accept) begin
        rem_d = rem_q - 16'd1;
        case (tgt_q)
          TGT_MC: begin
            we0_d   = 1'b1;
            addr0_d = {vlan_q, off_q};
            data0_d = cmd_data[MC_DW-1:0];
            off_d   = off_q + 1'b1;  // wraps within the VLAN slot
          end
          TGT_L3: begin
            we1_d   = 1'b1;
            addr1_d = vlan_q;
            data1_d = cmd_data[TBL_DW-1:0];
          end
          TGT_CHK: begin
            we2_d   = 1'b1;
            addr2_d = vlan_q;
            data2_d = cmd_data[TBL_DW-1:0];
          end
          default: ;
        endcase
        if (rem_q == 16'd1) state_d = S_DONE;
      end
      S_DRAIN: if (accept) begin
        rem_d = rem_q - 16'd1;
        if (rem_q == 16'd1) state_d = S_HDR;
      end
      S_DONE: state_d = S_HDR;
      default: state_d = S_HDR;
    endcase
    err_d = err_clr ? 1'b0 : (err_q | set_err);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HDR;
      tgt_q   <= '0;
      vlan_q  <= '0;
      off_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      we0_q   <= 1'b0;
      we1_q   <= 1'b0;
      we2_q   <= 1'b0;
      addr0_q <= '0;
      data0_q <= '0;
      addr1_q <= '0;
      data1_q <= '0;
      addr2_q <= '0;
      data2_q <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      vlan_q  <= vlan_d;
      off_q   <= off_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      we0_q   <= we0_d;
      we1_q   <= we1_d;
      we2_q   <= we2_d;
      addr0_q <= addr0_d;
      data0_q <= data0_d;
      addr1_q <= addr1_d;
      data1_q <= data1_d;
      addr2_q <= addr2_d;
      data2_q <= data2_d;
    end
  end

endmodule
